// File: rtl/temp_bcd_formatter_if.sv
// temp_bcd_formatter_if: sensor-side inputs and display-side outputs of temp_bcd_formatter.
// disp_sel exists only when TEMP_MINMAX_EN is defined.
interface temp_bcd_formatter_if #(
  parameter int TEMP_W = 13,
  parameter int DIGITS = 4
);
  logic [TEMP_W-1:0]   temp_in;
  logic                temp_rdy;
  logic                temp_err;
`ifdef TEMP_MINMAX_EN
  logic [1:0]          disp_sel;
`endif
  logic [4*DIGITS-1:0] bcd;
  logic                negative;
  logic [DIGITS-1:0]   dots;
  logic                overflow;
  logic                err_seen;
  logic                busy;
  logic                out_valid;
`ifdef TEMP_MINMAX_EN
  modport master (output temp_in, temp_rdy, temp_err, disp_sel,
                  input bcd, negative, dots, overflow, err_seen, busy, out_valid);
  modport slave (input temp_in, temp_rdy, temp_err, disp_sel,
                 output bcd, negative, dots, overflow, err_seen, busy, out_valid);
`else
  modport master (output temp_in, temp_rdy, temp_err,
                  input bcd, negative, dots, overflow, err_seen, busy, out_valid);
  modport slave (input temp_in, temp_rdy, temp_err,
                 output bcd, negative, dots, overflow, err_seen, busy, out_valid);
`endif
endinterface

// File: rtl/temp_bcd_formatter.sv
// temp_bcd_formatter: averages signed sensor readings and serially BCD-encodes the scaled result.
// Optional TEMP_MINMAX_EN adds running min/max of window averages selectable via disp_sel.
module temp_bcd_formatter #(
  parameter int TEMP_W    = 13,
  parameter int FRAC_BITS = 4,
  parameter int DECIMALS  = 1,
  parameter int DIGITS    = 4,
  parameter int AVG_LOG2  = 2
) (
  input logic clk,
  input logic reset_n,
  temp_bcd_formatter_if.slave b
);
  localparam int AW = TEMP_W + AVG_LOG2;
  localparam int BW = 4 * DIGITS;
  localparam logic [AVG_LOG2:0] LAST = (AVG_LOG2 + 1)'(2 ** AVG_LOG2 - 1);
  localparam logic [5:0] LASTB = 6'(BW - 1);
  localparam logic [DIGITS-1:0] DOTS = DECIMALS > 0 ? DIGITS'(1) << DECIMALS : '0;
  localparam logic [1:0] IDLE = 2'd0, SCALE = 2'd1, CONV = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic rdy_q, pending, neg_r, ovf_r;
  logic signed [AW-1:0] acc, sum;
  logic [AVG_LOG2:0] cnt;
  logic signed [TEMP_W-1:0] avg, new_avg, sel;
  logic [5:0] bc;
  logic [BW-1:0] bin, dd, adj;
  logic signed [63:0] s64;
  logic [63:0] mag, scaled, lim;
  logic rdy_edge, accept, err_edge, win_done;
`ifdef TEMP_MINMAX_EN
  logic signed [TEMP_W-1:0] min_avg, max_avg;
  logic have_mm;
  assign sel = b.disp_sel == 2'd1 ? min_avg : b.disp_sel == 2'd2 ? max_avg : avg;
`else
  assign sel = avg;
`endif
  assign rdy_edge = b.temp_rdy & ~rdy_q;
  assign accept   = rdy_edge & ~b.temp_err;
  assign err_edge = rdy_edge & b.temp_err;
  assign win_done = accept && cnt == LAST;
  assign sum      = acc + AW'($signed(b.temp_in));
  assign new_avg  = TEMP_W'(sum >>> AVG_LOG2);
  assign s64      = 64'(sel);
  assign mag      = s64[63] ? $unsigned(-s64) : $unsigned(s64);
  assign scaled   = (mag * 64'(10 ** DECIMALS)) >> FRAC_BITS;
  assign lim      = 64'(10 ** DIGITS);
  assign b.busy   = state != IDLE;
  // double-dabble correction applied before each shift
  always_comb begin
    adj = dd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = dd[4*i +: 4] >= 4'd5 ? dd[4*i +: 4] + 4'd3 : dd[4*i +: 4];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rdy_q       <= 1'b0;
      pending     <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      avg         <= '0;
      bc          <= '0;
      bin         <= '0;
      dd          <= '0;
      neg_r       <= 1'b0;
      ovf_r       <= 1'b0;
      b.bcd       <= '0;
      b.negative  <= 1'b0;
      b.dots      <= '0;
      b.overflow  <= 1'b0;
      b.err_seen  <= 1'b0;
      b.out_valid <= 1'b0;
`ifdef TEMP_MINMAX_EN
      min_avg     <= '0;
      max_avg     <= '0;
      have_mm     <= 1'b0;
`endif
    end else begin
      rdy_q       <= b.temp_rdy;
      b.out_valid <= 1'b0;
      b.dots      <= DOTS;
      if (err_edge) b.err_seen <= 1'b1;
      else if (accept) b.err_seen <= 1'b0;
      if (accept) begin
        acc <= win_done ? '0 : sum;
        cnt <= win_done ? '0 : cnt + 1'b1;
      end
      if (win_done) avg <= new_avg;
      case (state)
        IDLE: if (pending) begin
          pending <= 1'b0;
          state   <= SCALE;
        end
        SCALE: begin
          ovf_r <= scaled >= lim;
          neg_r <= s64[63] && scaled != 64'd0;
          bin   <= scaled >= lim ? BW'(lim - 64'd1) : BW'(scaled);
          dd    <= '0;
          bc    <= '0;
          state <= CONV;
        end
        CONV: begin
          {dd, bin} <= {adj[BW-2:0], bin, 1'b0};
          bc        <= bc + 6'd1;
          if (bc == LASTB) state <= DONE;
        end
        default: begin
          b.bcd       <= dd;
          b.negative  <= neg_r;
          b.overflow  <= ovf_r;
          b.out_valid <= 1'b1;
          state       <= IDLE;
        end
      endcase
      if (win_done) pending <= 1'b1;
`ifdef TEMP_MINMAX_EN
      if (win_done) begin
        have_mm <= 1'b1;
        if (!have_mm || new_avg < min_avg) min_avg <= new_avg;
        if (!have_mm || new_avg > max_avg) max_avg <= new_avg;
      end
`endif
    end
  end
endmodule

// File: tb/tb_temp_bcd_formatter.sv
// tb_temp_bcd_formatter: randomized and directed checks of temp_bcd_formatter against an arithmetic model.
// Two instances: defaults, and DIGITS=2/AVG_LOG2=0 for saturation and window-overwrite cases.
module tb_temp_bcd_formatter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  temp_bcd_formatter_if #(.TEMP_W(13), .DIGITS(4)) i1 ();
  temp_bcd_formatter_if #(.TEMP_W(13), .DIGITS(2)) i2 ();
  temp_bcd_formatter #(.TEMP_W(13), .FRAC_BITS(4), .DECIMALS(1), .DIGITS(4), .AVG_LOG2(2))
    dut1 (.clk(clk), .reset_n(reset_n), .b(i1));
  temp_bcd_formatter #(.TEMP_W(13), .FRAC_BITS(4), .DECIMALS(1), .DIGITS(2), .AVG_LOG2(0))
    dut2 (.clk(clk), .reset_n(reset_n), .b(i2));

  function automatic int sx(input logic [12:0] v);
    return v[12] ? int'(v) - 8192 : int'(v);
  endfunction

  // expected {negative, overflow, bcd}: floor average, scale by 10/16 toward zero, saturate, decimal digits
  function automatic logic [33:0] model(input int sum, input int n, input int digits);
    int avg, sc, lim;
    logic neg, ovf;
    logic [31:0] r;
    r = '0;
    avg = sum >= 0 ? sum / n : -((-sum + n - 1) / n);
    sc = (avg < 0 ? -avg : avg) * 10 / 16;
    neg = avg < 0 && sc != 0;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    ovf = sc >= lim;
    if (ovf) sc = lim - 1;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(sc % 10);
      sc = sc / 10;
    end
    return {neg, ovf, r};
  endfunction

  task automatic feed1(input logic [12:0] s[4], input int n, input bit wt, output int lat);
    for (int i = 0; i < n; i++) begin
      i1.temp_in = s[i];
      i1.temp_rdy = 1'b1;
      @(posedge clk); #1;
      i1.temp_rdy = 1'b0;
      if (i != n - 1) begin @(posedge clk); #1; end
    end
    lat = 0;
    if (wt)
      while (i1.out_valid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic run1(input logic [12:0] s[4], input string nm);
    int lat, sum;
    logic [33:0] e;
    feed1(s, 4, 1'b1, lat);
    sum = 0;
    for (int i = 0; i < 4; i++) sum += sx(s[i]);
    e = model(sum, 4, 4);
    checks += 4;
    if (lat !== 19) begin errors++; $display("FAIL %s latency got %0d expected 19", nm, lat); end
    if (i1.bcd !== e[15:0]) begin errors++; $display("FAIL %s bcd got %h expected %h", nm, i1.bcd, e[15:0]); end
    if (i1.negative !== e[33]) begin errors++; $display("FAIL %s negative got %b expected %b", nm, i1.negative, e[33]); end
    if (i1.overflow !== e[32]) begin errors++; $display("FAIL %s overflow got %b expected %b", nm, i1.overflow, e[32]); end
  endtask

  task automatic run2(input logic [12:0] v, input string nm);
    int lat;
    logic [33:0] e;
    e = model(sx(v), 1, 2);
    i2.temp_in = v;
    i2.temp_rdy = 1'b1;
    @(posedge clk); #1;
    i2.temp_rdy = 1'b0;
    lat = 0;
    while (i2.out_valid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    checks += 4;
    if (lat !== 11) begin errors++; $display("FAIL %s latency got %0d expected 11", nm, lat); end
    if (i2.bcd !== e[7:0]) begin errors++; $display("FAIL %s bcd got %h expected %h", nm, i2.bcd, e[7:0]); end
    if (i2.negative !== e[33]) begin errors++; $display("FAIL %s negative got %b expected %b", nm, i2.negative, e[33]); end
    if (i2.overflow !== e[32]) begin errors++; $display("FAIL %s overflow got %b expected %b", nm, i2.overflow, e[32]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks += 2;
    if ({i1.bcd, i1.negative, i1.dots, i1.overflow, i1.err_seen, i1.busy, i1.out_valid} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0", {i1.bcd, i1.negative, i1.dots, i1.overflow, i1.err_seen, i1.busy, i1.out_valid});
    end
    if ({i2.bcd, i2.dots, i2.busy, i2.out_valid} !== '0) begin errors++; $display("FAIL reset_outputs2 got nonzero expected 0"); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (i1.dots !== 4'b0010) begin errors++; $display("FAIL dots got %b expected 0010", i1.dots); end
    if (i2.dots !== 2'b10) begin errors++; $display("FAIL dots2 got %b expected 10", i2.dots); end
  endtask

  task automatic test_vectors;
    logic [15:0] held;
    run1('{13'h190, 13'h190, 13'h190, 13'h190}, "vec_400");
    held = i1.bcd;
    @(posedge clk); #1;
    checks += 2;
    if (i1.out_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse got %b expected 0", i1.out_valid); end
    if (i1.bcd !== held) begin errors++; $display("FAIL hold got %h expected %h", i1.bcd, held); end
    run1('{13'h1A5, 13'h1A5, 13'h1A5, 13'h1A5}, "vec_263");
    run1('{13'h190, 13'h190, 13'h191, 13'h191}, "vec_mixed");
    run1('{13'h1FF0, 13'h1FF0, 13'h1FF0, 13'h1FF0}, "vec_neg16");
    run1('{13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF}, "vec_negzero");
  endtask

  task automatic test_random;
    logic [12:0] s[4];
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 4; i++) s[i] = 13'($urandom_range(0, 8191));
      run1(s, "random");
    end
  endtask

  task automatic test_held_rdy;
    int lat;
    i1.temp_in = 13'h000;
    i1.temp_rdy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    i1.temp_rdy = 1'b0;
    @(posedge clk); #1;
    feed1('{13'h190, 13'h190, 13'h190, 13'h000}, 3, 1'b1, lat);
    checks += 2;
    if (lat !== 19) begin errors++; $display("FAIL held_latency got %0d expected 19", lat); end
    if (i1.bcd !== 16'h0187) begin errors++; $display("FAIL held_bcd got %h expected 0187", i1.bcd); end
  endtask

  task automatic test_err;
    int lat;
    i1.temp_in = 13'h0FFF;
    i1.temp_err = 1'b1;
    i1.temp_rdy = 1'b1;
    @(posedge clk); #1;
    i1.temp_rdy = 1'b0;
    i1.temp_err = 1'b0;
    checks++;
    if (i1.err_seen !== 1'b1) begin errors++; $display("FAIL err_set got %b expected 1", i1.err_seen); end
    @(posedge clk); #1;
    feed1('{13'h0A0, 13'h0A0, 13'h0A0, 13'h0A0}, 1, 1'b0, lat);
    checks++;
    if (i1.err_seen !== 1'b0) begin errors++; $display("FAIL err_clear got %b expected 0", i1.err_seen); end
    @(posedge clk); #1;
    feed1('{13'h0A0, 13'h0A0, 13'h0A0, 13'h0A0}, 3, 1'b1, lat);
    checks += 2;
    if (lat !== 19) begin errors++; $display("FAIL err_latency got %0d expected 19", lat); end
    if (i1.bcd !== 16'h0100) begin errors++; $display("FAIL err_bcd got %h expected 0100", i1.bcd); end
  endtask

  task automatic test_overflow;
    run2(13'h190, "ovf_pos");
    run2(13'h050, "small");
    run2(13'h1F60, "ovf_neg");
    for (int k = 0; k < 4; k++) run2(13'($urandom_range(0, 8191)), "random2");
  endtask

  task automatic test_back_to_back;
    logic [7:0] got[$];
    for (int c = 0; c < 60; c++) begin
      i2.temp_rdy = c == 0 || c == 2 || c == 4;
      i2.temp_in = c == 0 ? 13'h010 : c == 2 ? 13'h020 : 13'h030;
      @(posedge clk); #1;
      if (i2.out_valid === 1'b1) got.push_back(i2.bcd);
    end
    i2.temp_rdy = 1'b0;
    checks++;
    if (got.size() !== 2) begin errors++; $display("FAIL b2b_pulses got %0d expected 2", got.size()); end
    else begin
      checks += 2;
      if (got[0] !== 8'h10) begin errors++; $display("FAIL b2b_first got %h expected 10", got[0]); end
      if (got[1] !== 8'h30) begin errors++; $display("FAIL b2b_newest got %h expected 30", got[1]); end
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit seen;
    feed1('{13'h190, 13'h190, 13'h190, 13'h190}, 4, 1'b0, lat);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (i1.busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b expected 1", i1.busy); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({i1.bcd, i1.negative, i1.dots, i1.overflow, i1.err_seen, i1.busy, i1.out_valid} !== '0) begin
      errors++; $display("FAIL mid_reset got %h expected 0", {i1.bcd, i1.negative, i1.dots, i1.overflow, i1.err_seen, i1.busy, i1.out_valid});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (i1.out_valid === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_valid got %b expected 0", seen); end
  endtask

`ifdef TEMP_MINMAX_EN
  task automatic test_minmax;
    int lat;
    i1.disp_sel = 2'd0;
    run1('{13'h190, 13'h190, 13'h190, 13'h190}, "mm_a");
    run1('{13'h0A0, 13'h0A0, 13'h0A0, 13'h0A0}, "mm_b");
    run1('{13'h1A5, 13'h1A5, 13'h1A5, 13'h1A5}, "mm_c");
    i1.disp_sel = 2'd1;
    feed1('{13'h1A5, 13'h1A5, 13'h1A5, 13'h1A5}, 4, 1'b1, lat);
    checks++;
    if (i1.bcd !== 16'h0100) begin errors++; $display("FAIL min_bcd got %h expected 0100", i1.bcd); end
    i1.disp_sel = 2'd2;
    feed1('{13'h0A0, 13'h0A0, 13'h0A0, 13'h0A0}, 4, 1'b1, lat);
    checks++;
    if (i1.bcd !== 16'h0263) begin errors++; $display("FAIL max_bcd got %h expected 0263", i1.bcd); end
    i1.disp_sel = 2'd0;
  endtask
`endif

  initial begin
    i1.temp_in = '0; i1.temp_rdy = 1'b0; i1.temp_err = 1'b0;
    i2.temp_in = '0; i2.temp_rdy = 1'b0; i2.temp_err = 1'b0;
`ifdef TEMP_MINMAX_EN
    i1.disp_sel = 2'd0;
    i2.disp_sel = 2'd0;
`endif
    test_reset;
    test_vectors;
    test_random;
    test_held_rdy;
    test_err;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
`ifdef TEMP_MINMAX_EN
    test_minmax;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
